// File: rtl/brick_color_loader.sv
// Per-level colour loader: restarts the random colour generator and captures NUM_BRICKS colours into a RAM.
// Optional build macro BRICK_COLOR_SKIP_BLANK_EN: drop 8'hFF ("no color") samples instead of storing them.
module brick_color_loader #(
    parameter int          NUM_BRICKS    = 32,
    parameter int          TIMEOUT       = 16,
    parameter logic [7:0]  DEFAULT_COLOR = 8'h6D
) (
    input  logic                                                   clk,
    input  logic                                                   resetN,
    input  logic                                                   level_start,
    input  logic                                                   cfg_override,
    input  logic [3:0]                                             cfg_seed,
    input  logic [3:0]                                             cfg_jump,
    output logic                                                   gen_rst_n,
    output logic [3:0]                                             gen_init,
    output logic [3:0]                                             gen_jump,
    output logic                                                   gen_make,
    input  logic [7:0]                                             gen_dout,
    input  logic [7:0]                                             gen_counter,
    input  logic [((NUM_BRICKS > 1) ? $clog2(NUM_BRICKS) : 1)-1:0] rd_addr,
    output logic [7:0]                                             rd_data,
    output logic                                                   load_done,
    output logic                                                   load_err
);

    localparam int AW = (NUM_BRICKS > 1) ? $clog2(NUM_BRICKS) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, ARM, FIRE, FILL, PAD, DONE} state_t;

    state_t         state;
    logic [15:0]    lfsr;
    logic [3:0]     seed_q;
    logic [3:0]     jump_q;
    logic [AW-1:0]  wr_ptr;
    logic [7:0]     last_cnt;
    logic [WW-1:0]  watchdog;
    logic [7:0]     mem [NUM_BRICKS];

    logic           we;
    logic [7:0]     wdata;
    logic           cnt_changed;
    logic           is_blank;
    logic           last_entry;
    logic [3:0]     sel_seed;
    logic [3:0]     raw_jump;
    logic [3:0]     sel_jump;

    assign cnt_changed = (gen_counter != last_cnt);
    assign last_entry  = (wr_ptr == AW'(NUM_BRICKS - 1));
`ifdef BRICK_COLOR_SKIP_BLANK_EN
    assign is_blank = (gen_dout == 8'hFF);
`else
    assign is_blank = 1'b0;
`endif

    // Jump is forced into 2..15 so it always differs from the parked value 1.
    assign sel_seed = cfg_override ? cfg_seed : lfsr[3:0];
    assign raw_jump = cfg_override ? cfg_jump : lfsr[7:4];
    assign sel_jump = (raw_jump < 4'd2) ? raw_jump + 4'd2 : raw_jump;

    always_comb begin
        we    = 1'b0;
        wdata = gen_dout;
        if (!level_start) begin
            case (state)
                FILL: we = (gen_counter != 8'hFF) && cnt_changed && !is_blank;
                PAD: begin
                    we    = 1'b1;
                    wdata = DEFAULT_COLOR;
                end
                default: we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            lfsr      <= 16'hACE1;
            seed_q    <= '0;
            jump_q    <= '0;
            wr_ptr    <= '0;
            last_cnt  <= '0;
            watchdog  <= '0;
            gen_rst_n <= 1'b1;
            gen_init  <= 4'd3;
            gen_jump  <= 4'd1;
            gen_make  <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            if (level_start && state != CLEAR) begin
                state     <= CLEAR;
                gen_rst_n <= 1'b0;
                gen_init  <= 4'd3;
                gen_jump  <= 4'd1;
                gen_make  <= 1'b0;
                load_done <= 1'b0;
                load_err  <= 1'b0;
                wr_ptr    <= '0;
                seed_q    <= sel_seed;
                jump_q    <= sel_jump;
            end else begin
                case (state)
                    CLEAR: begin
                        state     <= ARM;
                        gen_rst_n <= 1'b1;
                        gen_init  <= seed_q;
                        gen_jump  <= 4'd1;
                    end
                    ARM: begin
                        state    <= FIRE;
                        gen_jump <= jump_q;
                        gen_make <= 1'b1;
                        last_cnt <= '0;
                        watchdog <= '0;
                    end
                    FIRE: state <= FILL;
                    FILL: begin
                        // A saturated generator counter cannot produce new colours: pad like a timeout.
                        if (gen_counter == 8'hFF) begin
                            state <= PAD;
                        end else if (cnt_changed) begin
                            last_cnt <= gen_counter;
                            watchdog <= '0;
                            if (!is_blank) begin
                                if (last_entry) begin
                                    state     <= DONE;
                                    gen_make  <= 1'b0;
                                    load_done <= 1'b1;
                                end else begin
                                    wr_ptr <= wr_ptr + 1'b1;
                                end
                            end
                        end else if (watchdog == WW'(TIMEOUT - 1)) begin
                            state <= PAD;
                        end else begin
                            watchdog <= watchdog + 1'b1;
                        end
                    end
                    PAD: begin
                        if (last_entry) begin
                            state     <= DONE;
                            gen_make  <= 1'b0;
                            load_done <= 1'b1;
                            load_err  <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_brick_color_loader.sv
// Randomised bench for brick_color_loader with an attached colour-generator model and a table-level reference.
module tb_brick_color_loader;

    localparam int NB = 16;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       level_start = 1'b0;
    logic       cfg_override = 1'b0;
    logic [3:0] cfg_seed = '0;
    logic [3:0] cfg_jump = '0;
    logic       gen_rst_n;
    logic [3:0] gen_init;
    logic [3:0] gen_jump;
    logic       gen_make;
    logic [7:0] gen_dout;
    logic [7:0] gen_counter;
    logic [3:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       load_done;
    logic       load_err;

    brick_color_loader #(.NUM_BRICKS(NB), .TIMEOUT(16), .DEFAULT_COLOR(8'h6D)) dut (
        .clk(clk), .resetN(resetN), .level_start(level_start),
        .cfg_override(cfg_override), .cfg_seed(cfg_seed), .cfg_jump(cfg_jump),
        .gen_rst_n(gen_rst_n), .gen_init(gen_init), .gen_jump(gen_jump), .gen_make(gen_make),
        .gen_dout(gen_dout), .gen_counter(gen_counter),
        .rd_addr(rd_addr), .rd_data(rd_data), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Colour generator model: palette walk by jump, counter bumps on each make cycle.
    logic [7:0] pal [16];
    logic [3:0] g_idx;
    logic [7:0] g_cnt;
    logic [7:0] g_dout;
    int         freeze_at = -1;

    assign gen_counter = g_cnt;
    assign gen_dout    = g_dout;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            g_idx  <= '0;
            g_cnt  <= '0;
            g_dout <= '0;
        end else if (!gen_rst_n) begin
            g_cnt <= '0;
            g_idx <= gen_init;
        end else if (!gen_make) begin
            g_idx <= gen_init;
        end else if (freeze_at < 0 || 32'(g_cnt) != freeze_at) begin
            g_cnt  <= g_cnt + 8'd1;
            g_dout <= pal[g_idx];
            g_idx  <= g_idx + gen_jump;
        end
    end

    // Reference LFSR state, tracking the DUT's free-running sequence.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge resetN) begin
        if (!resetN) m_lfsr <= 16'hACE1;
        else         m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    logic [7:0] exp_mem [NB];
    logic       exp_err;
    logic [3:0] exp_seed;
    logic [3:0] exp_jump;
    int         cyc;

    task automatic build_exp(input int frz);
        int n = 0;
        int limit = (frz < 0) ? 200 : frz;
        logic [3:0] idx = exp_seed;
        logic [7:0] v;
        for (int k = 0; k < limit && n < NB; k++) begin
            v   = pal[idx];
            idx = idx + exp_jump;
`ifdef BRICK_COLOR_SKIP_BLANK_EN
            if (v != 8'hFF) begin
                exp_mem[n] = v;
                n++;
            end
`else
            exp_mem[n] = v;
            n++;
`endif
        end
        exp_err = (n < NB);
        for (int i = n; i < NB; i++) exp_mem[i] = 8'h6D;
    endtask

    task automatic start_load(input logic ovr, input logic [3:0] cs, input logic [3:0] cj, input bit hold2);
        logic [3:0] raw;
        @(negedge clk);
        cfg_override = ovr;
        cfg_seed     = cs;
        cfg_jump     = cj;
        exp_seed     = ovr ? cs : m_lfsr[3:0];
        raw          = ovr ? cj : m_lfsr[7:4];
        exp_jump     = (raw < 4'd2) ? raw + 4'd2 : raw;
        level_start  = 1'b1;
        @(negedge clk);
        if (!hold2) level_start = 1'b0;
        check("clear_rstn", 32'(gen_rst_n), 32'd0);
        check("clear_init", 32'(gen_init), 32'd3);
        check("clear_done", 32'(load_done), 32'd0);
        @(negedge clk);
        level_start = 1'b0;
        check("arm_rstn", 32'(gen_rst_n), 32'd1);
        check("arm_init", 32'(gen_init), 32'(exp_seed));
        check("arm_jump", 32'(gen_jump), 32'd1);
        @(negedge clk);
        check("fire_jump", 32'(gen_jump), 32'(exp_jump));
        check("fire_make", 32'(gen_make), 32'd1);
        cyc = 3;
    endtask

    task automatic finish_load(input int frz);
        build_exp(frz);
        while (!load_done && cyc < 150) begin
            @(negedge clk);
            cyc++;
        end
        check("load_done", 32'(load_done), 32'd1);
`ifndef BRICK_COLOR_SKIP_BLANK_EN
        if (frz < 0) check("latency_ok", 32'(cyc <= NB + 5), 32'd1);
`endif
        check("load_err", 32'(load_err), 32'(exp_err));
        check("make_off", 32'(gen_make), 32'd0);
        for (int a = 0; a < NB; a++) begin
            rd_addr = 4'(a);
            @(negedge clk);
            check($sformatf("mem[%0d]", a), 32'(rd_data), 32'(exp_mem[a]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        pal[0]  = 8'h11; pal[1]  = 8'h60; pal[2]  = 8'h22; pal[3]  = 8'hFF;
        pal[4]  = 8'hFF; pal[5]  = 8'h1F; pal[6]  = 8'h44; pal[7]  = 8'hFF;
        pal[8]  = 8'h55; pal[9]  = 8'hFF; pal[10] = 8'h66; pal[11] = 8'h1C;
        pal[12] = 8'h77; pal[13] = 8'h03; pal[14] = 8'h88; pal[15] = 8'hFC;

        repeat (3) @(negedge clk);
        check("rst_gen_rst_n", 32'(gen_rst_n), 32'd1);
        check("rst_gen_init", 32'(gen_init), 32'd3);
        check("rst_gen_jump", 32'(gen_jump), 32'd1);
        check("rst_gen_make", 32'(gen_make), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        resetN = 1'b1;
        repeat (2) @(negedge clk);

        // Directed: seed 1 / jump 2 sequence, then the jump remap of 0 and 1.
        start_load(1'b1, 4'd1, 4'd2, 1'b0);
        finish_load(-1);
        start_load(1'b1, 4'd6, 4'd0, 1'b0);
        finish_load(-1);
        start_load(1'b1, 4'd9, 4'd1, 1'b0);
        finish_load(-1);

        // Frozen generator counter forces the timeout padding path.
        freeze_at = 5;
        start_load(1'b1, 4'd1, 4'd2, 1'b0);
        finish_load(5);
        freeze_at = -1;

        // Abort mid-fill, then a held level_start that must not stretch CLEAR.
        start_load(1'b1, 4'd3, 4'd7, 1'b0);
        repeat (6) @(negedge clk);
        check("abort_pre_done", 32'(load_done), 32'd0);
        start_load(1'b1, 4'd5, 4'd3, 1'b1);
        finish_load(-1);

        // Asynchronous reset in the middle of a fill.
        start_load(1'b0, 4'd0, 4'd0, 1'b0);
        repeat (4) @(negedge clk);
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_rstn", 32'(gen_rst_n), 32'd1);
        check("midrst_jump", 32'(gen_jump), 32'd1);
        check("midrst_init", 32'(gen_init), 32'd3);
        check("midrst_done", 32'(load_done), 32'd0);
        check("midrst_make", 32'(gen_make), 32'd0);
        resetN = 1'b1;
        repeat (3) @(negedge clk);
        start_load(1'b0, 4'd0, 4'd0, 1'b0);
        finish_load(-1);

        for (int it = 0; it < 12; it++) begin
            int frz;
            frz = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NB - 1)) : -1;
            freeze_at = frz;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            start_load(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
            finish_load(frz);
        end
        freeze_at = -1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/brick_color_loader.md
Name: brick_color_loader

Overview:
- Per-level sequencer for the random colour generator (jump/initColor/make → dout/counter).
- On each level start it picks a seed and jump, resets and restarts the generator, and captures NUM_BRICKS successive colours into an internal brick colour RAM.
- The brick-drawing logic then reads that RAM through a registered read port.

Parameters:
- NUM_BRICKS, 32, bricks per level = colours captured (1..255).
- TIMEOUT, 16, cycles without a generator counter change before a load is aborted.
- DEFAULT_COLOR, 8'h6D, fill value for uncaptured/aborted entries.

Ports:
- clk  in  1  clock
- resetN  in  1  asynchronous active-low reset
- level_start  in  1  one-cycle pulse: begin a new colour load
- cfg_override  in  1  1 = use cfg_seed/cfg_jump instead of LFSR
- cfg_seed  in  4  override initial colour index
- cfg_jump  in  4  override jump
- gen_rst_n  out  1  registered reset to the generator
- gen_init  out  4  initColor to the generator
- gen_jump  out  4  jump to the generator
- gen_make  out  1  make to the generator, high in FIRE/FILL
- gen_dout  in  8  generator colour
- gen_counter  in  8  generator counter
- rd_addr  in  $clog2(NUM_BRICKS)  brick index
- rd_data  out  8  colour, 1-cycle latency
- load_done  out  1  table valid
- load_err  out  1  last load aborted by timeout

Behaviour:
- Reset (async, resetN=0):
  - state=IDLE; gen_rst_n=1, gen_init=3, gen_jump=1, gen_make=0.
  - rd_data=0, load_done=0, load_err=0.
  - LFSR=16'hACE1; wr_ptr=0.
  - RAM contents undefined until the first load.
- LFSR:
  - 16-bit Galois, taps 16,14,13,11; advances every clock, including IDLE.
- Seed/jump selection at level_start:
  - seed = cfg_override ? cfg_seed : lfsr[3:0].
  - raw = cfg_override ? cfg_jump : lfsr[7:4].
  - jump = (raw<2) ? raw+2 : raw, so jump is always in 2..15. This guarantees a change from the parked value 1 and a non-constant sequence.
- States:
  - IDLE/DONE: wait for level_start → CLEAR.
  - CLEAR (1 cycle):
    - gen_rst_n=0, gen_init=3, gen_jump=1; load_done=0, load_err=0.
    - wr_ptr=0; latch seed/jump.
  - ARM (1 cycle): gen_rst_n=1, gen_init=seed, gen_jump=1 (init change lands while jump is stable).
  - FIRE (1 cycle):
    - gen_jump=jump, gen_make=1; last_cnt=0; watchdog=0 → FILL.
  - FILL:
    - When gen_counter != last_cnt: mem[wr_ptr] <= gen_dout, wr_ptr++, last_cnt <= gen_counter, watchdog=0.
    - Otherwise watchdog++.
    - After the NUM_BRICKS-th write (wr_ptr == NUM_BRICKS-1 being written) → DONE with load_done=1.
    - If watchdog reaches TIMEOUT: entries wr_ptr..NUM_BRICKS-1 are written DEFAULT_COLOR one per cycle, then DONE with load_done=1, load_err=1.
    - If gen_counter reaches 255 before the table is full: handled as timeout.
  - DONE: gen_make=0; gen_init/gen_jump hold their values.
- level_start handling:
  - Accepted in IDLE, DONE, ARM, FIRE and FILL; aborts the current load and goes to CLEAR.
  - Ignored while in CLEAR.
- Read port:
  - rd_data <= mem[rd_addr] every cycle, in all states.
  - rd_data holds stale/partial data while load_done=0; consumers gate on load_done.
  - A read and a write to the same address in one cycle returns the old value.
- Latency: level_start to load_done ≤ NUM_BRICKS+5 cycles without timeout.

Optional Feature:
- Macro: BRICK_COLOR_SKIP_BLANK_EN.
- Defined: gen_dout == 8'hFF ("no color") is not written and wr_ptr does not advance; last_cnt and watchdog still update. The fill ends on NUM_BRICKS non-blank writes, or on timeout/counter 255 with DEFAULT_COLOR padding.
- Undefined: 8'hFF entries are stored as-is (transparent bricks).

Test Plan:
- Reset mid-FILL (resetN low 2 cycles) → gen_rst_n=1, gen_jump=1, gen_init=3, load_done=0, state IDLE; a subsequent level_start completes a normal load.
- cfg_override=1, cfg_seed=1, cfg_jump=2, NUM_BRICKS=16, real generator attached, level_start → mem[0..7]=60,FF,1F,FF,FF,1C,03,FC, mem[8..15] repeat; load_done=1 within 21 cycles; load_err=0.
- Same stimulus with BRICK_COLOR_SKIP_BLANK_EN defined → mem[0..15]=60,1F,1C,03,FC,60,1F,1C,03,FC,60,1F,1C,03,FC,60.
- cfg_jump=0 and cfg_jump=1 → gen_jump driven as 2 and 3 respectively in FIRE.
- Generator model freezes gen_counter at 5 → after 16 idle cycles entries 5..NUM_BRICKS-1 = 6D; load_done=1, load_err=1.
- level_start pulsed during FILL at wr_ptr=7 → gen_rst_n low next cycle, load_done stays 0, full reload completes; back-to-back level_start pulses in CLEAR do not extend CLEAR.
